// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter.
//   DATA_W        : payload width of one frame (8 bits, LSB first on the line)
//   PAR_EVEN/ODD  : values of the parity-type select
//   uart_state_t  : frame-level FSM states, common to RX and TX
//   parity_bit()  : the parity bit that accompanies a byte for a parity type
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity: the bit makes the count of ones (data + parity) even.
    // Odd parity is the complement of that.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                        input logic              par_typ);
        return (^data) ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Signals between a UART receiver and the logic around it.
//   RX_IN      : serial line (idles high), asynchronous to the receiver clock
//   PAR_EN     : a parity bit follows the data bits
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   P_DATA     : last good byte, held between frames
//   DATA_VALID : one-cycle strobe, P_DATA was just updated
//   PAR_ERR    : one-cycle strobe, parity mismatch in the frame just ended
//   STP_ERR    : one-cycle strobe, stop bit sampled as 0
//
// Handshake: the result side has valid but no ready. DATA_VALID, PAR_ERR and
// STP_ERR are each exactly one cycle wide and cannot be stalled; a consumer
// must take them in that cycle. P_DATA is valid in the DATA_VALID cycle and
// stays unchanged until the next good frame.
//
// Modports: master = the line/config driver and result consumer,
//           slave  = the receiver.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic              RX_IN;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VALID;
    logic              PAR_ERR;
    logic              STP_ERR;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Line front end of the UART receiver: 2-flop synchronizer, per-bit edge
// counter and 3-sample majority vote around the bit centre.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_in       : raw serial line
//   cnt_en      : advance the edge counter (FSM is inside a frame)
//   cnt_clr     : hold the edge counter at 0 (FSM idle)
//   rx_s        : synchronized line, used by the FSM for start detection
//   sampled_bit : majority of the three samples, valid with sample_done
//   sample_done : the third sample is taken this cycle
//   bit_end     : last clock of the current bit period
// PRESCALE must be even and at least 6 so that the three sample points sit
// strictly inside the bit period.
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic rx_s,
    output logic sampled_bit,
    output logic sample_done,
    output logic bit_end
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] SAMP_0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SAMP_1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SAMP_2   = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic          rx_meta;
    logic [CW-1:0] edge_cnt;
    logic          samp_0;
    logic          samp_1;

    // Reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (cnt_en) begin
            edge_cnt <= (edge_cnt == CNT_LAST) ? '0 : edge_cnt + 1'b1;
        end
    end

    // The first two samples are stored; the third is used live so the
    // decision lands in the same cycle it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_0 <= 1'b1;
            samp_1 <= 1'b1;
        end else if (cnt_en) begin
            if (edge_cnt == SAMP_0) samp_0 <= rx_s;
            if (edge_cnt == SAMP_1) samp_1 <= rx_s;
        end
    end

    assign sampled_bit = (samp_0 & samp_1) | (samp_0 & rx_s) | (samp_1 & rx_s);
    assign sample_done = cnt_en && (edge_cnt == SAMP_2);
    assign bit_end     = cnt_en && (edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit, 8 data bits LSB first, optional parity, one stop
// bit, oversampled at PRESCALE clocks per bit.
//   CLK       : clock, all logic rising-edge
//   RST       : asynchronous active-low reset
//   bus       : uart_rx_if.slave -- line, parity config and results
//   dbg_state : current frame FSM state
// The frame result is evaluated in the cycle after the stop-bit decision and
// the FSM returns to IDLE there, without waiting for the end of the stop bit,
// so a start bit that follows right after the stop-bit centre is caught.
// A frame with a parity or stop error never touches P_DATA.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic        CLK,
    input  logic        RST,
    uart_rx_if.slave    bus,
    output uart_state_t dbg_state
);

    uart_state_t       state;
    uart_state_t       next_state;

    logic              rx_s;
    logic              sampled_bit;
    logic              sample_done;
    logic              bit_end;

    logic              cnt_en;
    logic              cnt_clr;
    logic              start_frame;
    logic              bit_adv;
    logic              shift_en;
    logic              par_chk;
    logic              frame_done;

    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_en_q;
    logic              par_typ_q;
    logic              par_mis;
    logic              par_fail;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (bus.RX_IN),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .rx_s        (rx_s),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    // ---- state register ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // ---- next-state logic ----
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (!rx_s) next_state = START;
            // A start bit that votes high was a glitch. Otherwise the vote
            // was low and the FSM moves on at the end of the bit.
            START:  if (sample_done && sampled_bit) next_state = IDLE;
                    else if (bit_end)               next_state = DATA;
            DATA:   if (bit_end && (bit_cnt == 3'd7))
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) next_state = STOP;
            STOP:   if (sample_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---- output / control logic ----
    always_comb begin
        cnt_clr     = (state == IDLE);
        cnt_en      = (state != IDLE);
        start_frame = (state == IDLE) && !rx_s;
        bit_adv     = (state == DATA) && bit_end;
        shift_en    = (state == DATA) && sample_done;
        par_chk     = (state == PARITY) && sample_done;
        frame_done  = (state == STOP) && sample_done;
    end

    assign dbg_state = state;

    // ---- frame datapath ----
    // Parity config is captured at start detection so mid-frame changes on
    // PAR_EN/PAR_TYP cannot affect the frame being received.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_mis   <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_cnt   <= '0;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                par_mis   <= 1'b0;
            end
            if (bit_adv)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift_reg[bit_cnt] <= sampled_bit;
            if (par_chk)  par_mis <= (sampled_bit != parity_bit(shift_reg, par_typ_q));
        end
    end

    assign par_fail = par_en_q && par_mis;

    // ---- result registers ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.P_DATA     <= '0;
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
        end else begin
            bus.DATA_VALID <= 1'b0;
            bus.PAR_ERR    <= 1'b0;
            bus.STP_ERR    <= 1'b0;
            if (frame_done) begin
                bus.STP_ERR <= !sampled_bit;
                bus.PAR_ERR <= par_fail;
                if (sampled_bit && !par_fail) begin
                    bus.DATA_VALID <= 1'b1;
                    bus.P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are driven bit by bit on RX_IN;
// every strobe cycle is recorded as {cycle, STP_ERR, PAR_ERR, DATA_VALID,
// P_DATA} and matched against a frame-level reference model that predicts the
// outcome and the strobe cycle from the frame contents alone.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int P  = 8;
    localparam int EW = 43;   // 32-bit cycle stamp + 3 flags + 8-bit data

    logic        CLK = 1'b0;
    logic        RST;
    uart_state_t dbg_state;
    uart_rx_if   bus ();

    uart_rx #(.PRESCALE(P)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---- clock / reset ----
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    // ---- scoreboard state ----
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [EW-1:0] exp_w;
    logic [EW-1:0] obs_w;
    logic [7:0]    model_pdata = 8'h00;
    int            checks   = 0;
    int            failures = 0;

    // Record every cycle in which any result strobe is high.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR))
            obs_q.push_back({32'(cyc), bus.STP_ERR, bus.PAR_ERR, bus.DATA_VALID, bus.P_DATA});
    end

    // ---- reference model ----
    // Line timing from the fall driven at cycle start_cyc: 2 synchronizer
    // clocks + 1 to detection, stop decision (9+PAR_EN)*P + P/2+1 later,
    // strobes one clock after that.
    task automatic predict(input int start_cyc, input logic [7:0] d, input bit pen,
                           input bit ptyp, input bit pbit, input bit stop);
        int ones;
        bit perr;
        bit serr;
        bit dv;
        int when;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        perr = pen && (((ones + int'(pbit)) % 2) != int'(ptyp));
        serr = !stop;
        dv   = !perr && !serr;
        if (dv) model_pdata = d;
        when = start_cyc + 4 + (9 + int'(pen)) * P + P / 2 + 1;
        exp_q.push_back({32'(when), serr, perr, dv, model_pdata});
    endtask

    function automatic bit good_parity(input logic [7:0] d, input bit ptyp);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return bit'((ones + int'(ptyp)) % 2);
    endfunction

    // ---- drivers (called at a falling clock edge) ----
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                              input bit pbit, input bit stop, input int stop_len,
                              input bit flip, output int start_cyc);
        bus.PAR_EN  = pen;
        bus.PAR_TYP = ptyp;
        start_cyc   = cyc;
        bus.RX_IN   = 1'b0;
        repeat (P) @(negedge CLK);
        if (flip) begin
            bus.PAR_EN  = 1'($urandom_range(0, 1));
            bus.PAR_TYP = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            bus.RX_IN = d[i];
            repeat (P) @(negedge CLK);
        end
        if (pen) begin
            bus.RX_IN = pbit;
            repeat (P) @(negedge CLK);
        end
        bus.RX_IN = stop;
        repeat (stop_len) @(negedge CLK);
        bus.RX_IN = 1'b1;
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
    endtask

    // ---- tests ----
    task automatic test_reset();
        RST         = 1'b0;
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA); end
        checks++;
        if (bus.DATA_VALID !== 1'b0) begin failures++; $display("FAIL reset_dv: got %b expected 0", bus.DATA_VALID); end
        checks++;
        if (bus.PAR_ERR !== 1'b0) begin failures++; $display("FAIL reset_par_err: got %b expected 0", bus.PAR_ERR); end
        checks++;
        if (bus.STP_ERR !== 1'b0) begin failures++; $display("FAIL reset_stp_err: got %b expected 0", bus.STP_ERR); end
        checks++;
        if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    endtask

    task automatic test_basic();
        int sc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0, sc);
        predict(sc, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL basic_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL basic_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL basic_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_parity();
        int sc;
        send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1, P, 1'b0, sc);
        predict(sc, 8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, PAR_ODD, 1'b1, 1'b1, P, 1'b0, sc);
        predict(sc, 8'h3C, 1'b1, PAR_ODD, 1'b1, 1'b1);
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL parity_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL parity_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL parity_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_parity_error();
        int sc;
        send_frame(8'h01, 1'b1, PAR_EVEN, 1'b0, 1'b1, P, 1'b0, sc);
        predict(sc, 8'h01, 1'b1, PAR_EVEN, 1'b0, 1'b1);
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL par_err_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL par_err_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL par_err_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
        checks++;
        if (bus.P_DATA !== model_pdata) begin failures++; $display("FAIL par_err_hold: got %h expected %h", bus.P_DATA, model_pdata); end
    endtask

    // Bad stop bit, then a good frame whose start bit begins right after the
    // stop-bit centre (the line never returns high between them).
    task automatic test_back_to_back();
        int sc;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, P / 2 + 3, 1'b0, sc);
        predict(sc, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0, sc);
        predict(sc, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL b2b_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL b2b_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch();
        int sc;
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (15) @(negedge CLK);
        checks++;
        if (dbg_state !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected %0d", dbg_state, IDLE); end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_strobe: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0, sc);
        predict(sc, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL glitch_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL glitch_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_mid_frame_reset();
        int         sc;
        logic [7:0] d;
        d = 8'h81;
        bus.PAR_EN = 1'b0;
        bus.RX_IN  = 1'b0;
        repeat (P) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = d[i];
            repeat (P) @(negedge CLK);
        end
        bus.RX_IN = d[4];
        repeat (P / 2) @(negedge CLK);
        RST       = 1'b0;
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.P_DATA !== 8'h00) begin failures++; $display("FAIL rst_mid_pdata: got %h expected 00", bus.P_DATA); end
        checks++;
        if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, IDLE); end
        checks++;
        if (bus.DATA_VALID !== 1'b0) begin failures++; $display("FAIL rst_mid_dv: got %b expected 0", bus.DATA_VALID); end
        RST = 1'b1;
        model_pdata = 8'h00;
        exp_q.delete();
        repeat (P * 4) @(negedge CLK);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_strobe: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, P / 2 + 3, 1'b0, sc);
        predict(sc, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.P_DATA !== 8'h00) begin failures++; $display("FAIL rst_mid_hold: got %h expected 00", bus.P_DATA); end
        wait_events(exp_q.size(), 200);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rst_mid_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL rst_mid_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    // Random bytes, parity config, occasional bad parity/stop bits, config
    // changes mid-frame and idle gaps from zero upward.
    task automatic test_random();
        int         sc;
        logic [7:0] d;
        bit         pen;
        bit         ptyp;
        bit         pbit;
        bit         stop;
        bit         flip;
        int         gap;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            pbit = good_parity(d, ptyp);
            if ($urandom_range(0, 5) == 0) pbit = ~pbit;
            stop = ($urandom_range(0, 5) != 0);
            flip = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 5);
            send_frame(d, pen, ptyp, pbit, stop, P / 2 + 3, flip, sc);
            predict(sc, d, pen, ptyp, pbit, stop);
            repeat (gap) @(negedge CLK);
        end
        wait_events(exp_q.size(), 400);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL random_event: got none expected %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin failures++; $display("FAIL random_event: got cyc=%0d s/p/v=%b%b%b data=%h expected cyc=%0d s/p/v=%b%b%b data=%h", obs_w[42:11], obs_w[10], obs_w[9], obs_w[8], obs_w[7:0], exp_w[42:11], exp_w[10], exp_w[9], exp_w[8], exp_w[7:0]); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL random_extra: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    // ---- sequence and report ----
    initial begin
        @(negedge CLK);
        test_reset();
        test_basic();
        test_parity();
        test_parity_error();
        test_back_to_back();
        test_glitch();
        test_mid_frame_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
